// File: rtl/fir_stream_feeder.sv
// FIFO-buffered upstream driver for the FIR core: issues one sample at a time, captures the result onto a valid/ready stream.
// Defining FIR_STREAM_FEEDER_TIMEOUT_EN builds a WAIT-state watchdog that raises a sticky timeout_err.
module fir_stream_feeder #(
    parameter int WIDTH          = 16,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [WIDTH-1:0]         fir_input,
    output logic                     fir_input_valid,
    input  logic [WIDTH-1:0]         fir_output,
    input  logic                     fir_output_valid,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW-1:0] PTR_ONE   = 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("fir_stream_feeder: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_fir_input;
    logic [WIDTH-1:0] r_m_data;
    logic             r_m_valid;

    logic w_push;
    logic w_pop;
    logic w_capture;
    logic w_expire;

    assign s_ready   = (r_count != FIFO_FULL);
    assign w_push    = s_valid && s_ready;
    // Issue only when the output register will be free by the time the result returns.
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0) && (!r_m_valid || m_ready);
    assign w_capture = (r_state == S_WAIT) && fir_output_valid;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_fir_input <= '0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_m_data  <= fir_output;
                r_m_valid <= 1'b1;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_fir_input <= r_mem[r_rd_ptr];
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (w_capture || w_expire) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FIR_STREAM_FEEDER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [WDW-1:0] WD_ONE  = 1;

    logic [WDW-1:0] r_wdog;
    logic           r_timeout_err;

    // A result arriving on the expiry cycle is captured rather than flagged.
    assign w_expire = (r_state == S_WAIT) && !fir_output_valid && (r_wdog == WD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_wdog <= '0;
            end else if (r_state == S_WAIT && !w_capture && !w_expire) begin
                r_wdog <= r_wdog + WD_ONE;
            end
            if (w_expire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_expire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign fir_input       = r_fir_input;
    assign fir_input_valid = (r_state == S_ISSUE);
    assign m_data          = r_m_data;
    assign m_valid         = r_m_valid;
    assign fifo_count      = r_count;
    assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_fir_stream_feeder.sv
// Self-checking bench for fir_stream_feeder with a behavioural FIR model (result = sample + 16'h0333).
// Define FIR_STREAM_FEEDER_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES=16.
module tb_fir_stream_feeder;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam logic [15:0] FIR_OFFSET = 16'h0333;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] fir_input;
    logic             fir_input_valid;
    logic [WIDTH-1:0] fir_output;
    logic             fir_output_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [$clog2(DEPTH):0] fifo_count;
    logic             busy;
    logic             timeout_err;

    always #5 clk = ~clk;

    fir_stream_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT_CYCLES(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .fir_input        (fir_input),
        .fir_input_valid  (fir_input_valid),
        .fir_output       (fir_output),
        .fir_output_valid (fir_output_valid),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .fifo_count       (fifo_count),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    typedef struct {
        logic [15:0] sData;
        int          firLat;
        logic [15:0] expOut;
    } vecT;

    vecT         vecs[6];
    logic [15:0] sbQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          issueCount = 0;
    int          outCount = 0;
    int          firLatency = 1;
    bit          firStall = 1'b0;
    bit          firPend = 1'b0;
    int          firCnt = 0;
    logic [15:0] firVal = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic ready);
        s_valid = valid;
        s_data  = data;
        m_ready = ready;
    endtask

    // One clock: scoreboard push/pop around the edge, then the FIR model reacts.
    task automatic step();
        logic        hs;
        logic [15:0] hsData;
        hs     = m_valid && m_ready;
        hsData = m_data;
        if (s_valid && s_ready) sbQ.push_back(s_data + FIR_OFFSET);
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            outCount++;
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected: got %0h, expected no output (cycle %0d)", hsData, cyc);
            end else begin
                checkOutput("sb_data", hsData, sbQ.pop_front());
            end
        end
        fir_output_valid = 1'b0;
        if (firPend && !firStall) begin
            if (firCnt == 0) begin
                fir_output_valid = 1'b1;
                fir_output       = firVal + FIR_OFFSET;
                firPend          = 1'b0;
            end else begin
                firCnt--;
            end
        end
        if (fir_input_valid) begin
            issueCount++;
            firPend = 1'b1;
            firCnt  = firLatency;
            firVal  = fir_input;
        end
    endtask

    task automatic waitMValid(input int bound, output int waited);
        waited = 0;
        while (!m_valid && waited < bound) begin
            step();
            waited++;
        end
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while ((sbQ.size() != 0 || busy || fifo_count != 0 || m_valid) && n < bound) begin
            step();
            n++;
        end
        checkOutput(name, sbQ.size(), 0);
    endtask

    initial begin
        int waited;
        int accepted;
        int sent;
        int outBase;
        int baseIssue;

        vecs[0] = '{16'hFFFF, 1, 16'h0332};
        vecs[1] = '{16'h0000, 5, 16'h0333};
        vecs[2] = '{16'h8000, 2, 16'h8333};
        vecs[3] = '{16'h7CCD, 4, 16'h8000};
        vecs[4] = '{16'hA5A5, 0, 16'hA8D8};
        vecs[5] = '{16'h1234, 3, 16'h1567};

        reset            = 1'b0;
        fir_output       = '0;
        fir_output_valid = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        #12;
        checkOutput("rst_count", fifo_count, 0);
        checkOutput("rst_s_ready", s_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_fiv", fir_input_valid, 0);
        checkOutput("rst_timeout_err", timeout_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single sample with the exact test-plan timing.
        firLatency = 67;
        applyStimulus(1'b1, 16'h0123, 1'b0);
        cyc = 0;
        step();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t1_fiv_c1", fir_input_valid, 0);
        checkOutput("t1_count_c1", fifo_count, 1);
        step();
        checkOutput("t1_fiv_c2", fir_input_valid, 1);
        checkOutput("t1_fir_input", fir_input, 16'h0123);
        checkOutput("t1_busy_c2", busy, 1);
        step();
        checkOutput("t1_fiv_c3", fir_input_valid, 0);
        checkOutput("t1_fir_input_hold", fir_input, 16'h0123);
        while (cyc < 70) step();
        checkOutput("t1_m_valid_c70", m_valid, 0);
        step();
        checkOutput("t1_m_valid_c71", m_valid, 1);
        checkOutput("t1_m_data_c71", m_data, 16'h0456);
        step();
        checkOutput("t1_m_valid_held", m_valid, 1);
        applyStimulus(1'b0, '0, 1'b1);
        step();
        checkOutput("t1_m_valid_cleared", m_valid, 0);
        checkOutput("t1_busy_idle", busy, 0);
        applyStimulus(1'b0, '0, 1'b0);

        // Table-driven single transactions with varying FIR latency.
        for (int i = 0; i < 6; i++) begin
            firLatency = vecs[i].firLat;
            applyStimulus(1'b1, vecs[i].sData, 1'b0);
            step();
            applyStimulus(1'b0, '0, 1'b0);
            step();
            checkOutput($sformatf("vec%0d_fir_input", i), fir_input, 32'(vecs[i].sData));
            waitMValid(40, waited);
            checkOutput($sformatf("vec%0d_latency", i), waited, vecs[i].firLat + 2);
            checkOutput($sformatf("vec%0d_m_data", i), m_data, 32'(vecs[i].expOut));
            applyStimulus(1'b0, '0, 1'b1);
            step();
            applyStimulus(1'b0, '0, 1'b0);
        end

        // Fill the FIFO while the FIR is stalled in WAIT.
        firLatency = 1;
        firStall   = 1'b1;
        accepted   = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 16'h1000 + 16'(accepted), 1'b1);
            if (s_ready) accepted++;
            step();
        end
        checkOutput("fill_accepted", accepted, 9);
        checkOutput("fill_count", fifo_count, 8);
        checkOutput("fill_s_ready", s_ready, 0);
        checkOutput("fill_busy", busy, 1);
        firStall = 1'b0;
        waited   = 0;
        while (accepted < 10 && waited < 60) begin
            applyStimulus(1'b1, 16'h1000 + 16'(accepted), 1'b1);
            if (s_ready) accepted++;
            step();
            waited++;
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("fill_tenth_accepted", accepted, 10);
        drain("fill_drain", 300);

        // Downstream stall holds one result and blocks further issues.
        firLatency = 2;
        baseIssue  = issueCount;
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 16'h2000 + 16'(k), 1'b0);
            step();
        end
        applyStimulus(1'b0, '0, 1'b0);
        repeat (25) step();
        checkOutput("stall_issues", issueCount - baseIssue, 1);
        checkOutput("stall_m_valid", m_valid, 1);
        checkOutput("stall_m_data", m_data, 16'h2334);
        checkOutput("stall_busy", busy, 0);
        checkOutput("stall_count", fifo_count, 2);
        applyStimulus(1'b0, '0, 1'b1);
        drain("stall_drain", 100);

        // Push and pop in the same cycle at count 4.
        applyStimulus(1'b0, '0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 16'h3000 + 16'(k), 1'b0);
            step();
        end
        applyStimulus(1'b0, '0, 1'b0);
        repeat (10) step();
        checkOutput("pp_pre_count", fifo_count, 4);
        checkOutput("pp_pre_m_valid", m_valid, 1);
        applyStimulus(1'b1, 16'h3005, 1'b1);
        step();
        checkOutput("pp_count", fifo_count, 4);
        checkOutput("pp_busy", busy, 1);
        applyStimulus(1'b0, '0, 1'b1);
        drain("pp_drain", 200);

        // Pointer wrap with random gaps, backpressure and FIR latency.
        outBase = outCount;
        sent    = 0;
        waited  = 0;
        while (sent < 20 && waited < 2000) begin
            firLatency = $urandom_range(0, 3);
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
            if (s_valid && s_ready) sent++;
            step();
            waited++;
        end
        applyStimulus(1'b0, '0, 1'b1);
        drain("wrap_drain", 500);
        checkOutput("wrap_outputs", outCount - outBase, 20);

        // Asynchronous reset while waiting on the FIR.
        firStall = 1'b1;
        firLatency = 1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 16'h4000 + 16'(k), 1'b1);
            step();
        end
        applyStimulus(1'b0, '0, 1'b1);
        repeat (2) step();
        checkOutput("rst_pre_busy", busy, 1);
        checkOutput("rst_pre_count", fifo_count, 2);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_count", fifo_count, 0);
        checkOutput("arst_s_ready", s_ready, 1);
        checkOutput("arst_fir_input", fir_input, 0);
        checkOutput("arst_m_data", m_data, 0);
        checkOutput("arst_m_valid", m_valid, 0);
        checkOutput("arst_fiv", fir_input_valid, 0);
        sbQ.delete();
        #2;
        reset    = 1'b1;
        firStall = 1'b0;
        outBase  = outCount;
        repeat (6) step();
        checkOutput("arst_late_m_valid", m_valid, 0);
        checkOutput("arst_late_busy", busy, 0);
        checkOutput("arst_late_outputs", outCount - outBase, 0);
        firPend = 1'b0;

`ifdef FIR_STREAM_FEEDER_TIMEOUT_EN
        // Watchdog: FIR never answers the first sample.
        firStall = 1'b1;
        applyStimulus(1'b1, 16'h5001, 1'b1);
        step();
        applyStimulus(1'b1, 16'h5002, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("to_issue", fir_input_valid, 1);
        repeat (16) step();
        checkOutput("to_err_before", timeout_err, 0);
        checkOutput("to_busy_before", busy, 1);
        step();
        checkOutput("to_err", timeout_err, 1);
        checkOutput("to_busy_after", busy, 0);
        checkOutput("to_no_m_valid", m_valid, 0);
        void'(sbQ.pop_front());
        firStall = 1'b0;
        step();
        checkOutput("to_next_issue", fir_input_valid, 1);
        checkOutput("to_next_input", fir_input, 16'h5002);
        drain("to_drain", 100);
        checkOutput("to_err_sticky", timeout_err, 1);
`else
        checkOutput("no_timeout_err", timeout_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
